// File: rtl/factor_game_ctrl.sv
// factor_game_ctrl: N-player round controller for the factorisation quiz.
// Tracks per-player HP and liveness, sequences the question index, enforces an
// answer time limit and detects the last player standing.
// Optional build macro FACTOR_SCORE_EN adds a per-player 4-bit win counter on SCORE.
module factor_game_ctrl #(
  parameter int N_PLAYERS = 2,
  parameter int HP_W      = 2,
  parameter int HP_INIT   = 3,
  parameter int NUM_W     = 4,
  parameter int NUM_Q     = 16,
  parameter int TMO_W     = 32,
  parameter int TMO_CYC   = 500000000
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       READY_IN,
  input  logic                       QUE_IN,
  input  logic [N_PLAYERS-1:0]       ANS_VALID,
  input  logic [N_PLAYERS-1:0]       ANS_OK,
  output logic [3:0]                 STATE,
  output logic [NUM_W-1:0]           NUM,
  output logic                       NUM_LD,
  output logic [N_PLAYERS*HP_W-1:0]  HP,
  output logic [N_PLAYERS-1:0]       ACTIVE,
  output logic [2:0]                 WINNER,
  output logic                       TMO,
  output logic                       LEDR
`ifdef FACTOR_SCORE_EN
  ,
  output logic [N_PLAYERS*4-1:0]     SCORE
`endif
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_READY  = 4'd1,
    S_ANSWER = 4'd2,
    S_JUDGE  = 4'd3,
    S_OVER   = 4'd4
  } state_t;

  localparam logic [HP_W-1:0]  HP_LOAD  = HP_W'(HP_INIT);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC - 1);
  localparam logic [NUM_W-1:0] NUM_LAST = NUM_W'(NUM_Q - 1);
  localparam logic [2:0]       NO_WIN   = 3'd7;

  state_t                 state_reg;
  logic [NUM_W-1:0]       num_reg;
  logic                   num_ld_reg;
  logic [HP_W-1:0]        hp_reg [N_PLAYERS];
  logic [N_PLAYERS-1:0]   active_reg;
  logic [N_PLAYERS-1:0]   answered_reg;
  logic [2:0]             winner_reg;
  logic                   tmo_reg;
  logic                   ledr_reg;
  logic [TMO_W-1:0]       timer_reg;
`ifdef FACTOR_SCORE_EN
  logic [3:0]             score_reg [N_PLAYERS];
`endif

  logic [N_PLAYERS-1:0]   elig;
  logic [N_PLAYERS-1:0]   correct;
  logic [N_PLAYERS-1:0]   wrong;
  logic [N_PLAYERS-1:0]   done_mask;
  logic [N_PLAYERS-1:0]   pen_mask;
  logic [N_PLAYERS-1:0]   survive;
  logic                   any_correct;
  logic                   all_wrong;
  logic                   timeout_hit;
  logic [2:0]             first_idx;
  logic [2:0]             alive_cnt;
  logic [2:0]             alive_idx;

  // Qualify this cycle's submissions and work out penalties and survivors
  always_comb begin
    elig        = ANS_VALID & active_reg & ~answered_reg;
    correct     = elig & ANS_OK;
    wrong       = elig & ~ANS_OK;
    done_mask   = answered_reg | wrong;
    any_correct = |correct;
    all_wrong   = ((done_mask & active_reg) == active_reg);
    timeout_hit = !any_correct && !all_wrong && (timer_reg == '0);
    // Timeout only penalises players who had not already been charged this round
    pen_mask    = wrong | (timeout_hit ? (active_reg & ~done_mask) : '0);
    first_idx   = NO_WIN;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (correct[i]) first_idx = 3'(i);
    end
    survive   = '0;
    alive_cnt = 3'd0;
    alive_idx = NO_WIN;
    for (int i = 0; i < N_PLAYERS; i++) begin
      survive[i] = active_reg[i] && (hp_reg[i] != '0);
      if (survive[i]) begin
        alive_cnt = alive_cnt + 3'd1;
        alive_idx = 3'(i);
      end
    end
  end

  // Round state machine with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      num_reg      <= '0;
      num_ld_reg   <= 1'b0;
      active_reg   <= '1;
      answered_reg <= '0;
      winner_reg   <= NO_WIN;
      tmo_reg      <= 1'b0;
      ledr_reg     <= 1'b0;
      timer_reg    <= '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        hp_reg[i] <= HP_LOAD;
`ifdef FACTOR_SCORE_EN
        score_reg[i] <= 4'd0;
`endif
      end
    end else begin
      num_ld_reg <= 1'b0;
      tmo_reg    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (READY_IN) begin
            state_reg  <= S_READY;
            active_reg <= '1;
            num_reg    <= '0;
            num_ld_reg <= 1'b1;
            winner_reg <= NO_WIN;
            for (int i = 0; i < N_PLAYERS; i++) begin
              hp_reg[i] <= HP_LOAD;
`ifdef FACTOR_SCORE_EN
              score_reg[i] <= 4'd0;
`endif
            end
          end
        end
        S_READY: begin
          if (QUE_IN) begin
            state_reg    <= S_ANSWER;
            timer_reg    <= TMO_LOAD;
            answered_reg <= '0;
            winner_reg   <= NO_WIN;
          end
        end
        S_ANSWER: begin
          answered_reg <= done_mask;
          for (int i = 0; i < N_PLAYERS; i++) begin
            if (pen_mask[i] && (hp_reg[i] != '0)) hp_reg[i] <= hp_reg[i] - HP_W'(1);
`ifdef FACTOR_SCORE_EN
            if (any_correct && (first_idx == 3'(i)) && (score_reg[i] != 4'hF))
              score_reg[i] <= score_reg[i] + 4'd1;
`endif
          end
          if (any_correct) begin
            winner_reg <= first_idx;
            state_reg  <= S_JUDGE;
          end else if (all_wrong) begin
            winner_reg <= NO_WIN;
            state_reg  <= S_JUDGE;
          end else if (timeout_hit) begin
            tmo_reg    <= 1'b1;
            winner_reg <= NO_WIN;
            state_reg  <= S_JUDGE;
          end else begin
            timer_reg <= timer_reg - TMO_W'(1);
          end
        end
        S_JUDGE: begin
          active_reg <= survive;
          if ((N_PLAYERS > 1) && (alive_cnt <= 3'd1)) begin
            state_reg  <= S_OVER;
            ledr_reg   <= 1'b1;
            winner_reg <= (alive_cnt == 3'd1) ? alive_idx : NO_WIN;
          end else if ((N_PLAYERS == 1) && !survive[0]) begin
            state_reg  <= S_OVER;
            ledr_reg   <= 1'b1;
            winner_reg <= NO_WIN;
          end else if ((N_PLAYERS == 1) && (num_reg == NUM_LAST) && (winner_reg == 3'd0)) begin
            state_reg  <= S_OVER;
            ledr_reg   <= 1'b1;
            winner_reg <= 3'd0;
          end else begin
            state_reg  <= S_READY;
            num_reg    <= (num_reg == NUM_LAST) ? '0 : num_reg + NUM_W'(1);
            num_ld_reg <= 1'b1;
          end
        end
        S_OVER: begin
          if (READY_IN) begin
            state_reg <= S_IDLE;
            ledr_reg  <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign STATE  = state_reg;
  assign NUM    = num_reg;
  assign NUM_LD = num_ld_reg;
  assign ACTIVE = active_reg;
  assign WINNER = winner_reg;
  assign TMO    = tmo_reg;
  assign LEDR   = ledr_reg;

  generate
    for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_pack
      assign HP[gi*HP_W +: HP_W] = hp_reg[gi];
`ifdef FACTOR_SCORE_EN
      assign SCORE[gi*4 +: 4] = score_reg[gi];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_factor_game_ctrl.sv
// Bench for factor_game_ctrl: randomised rounds on a 2-player instance checked
// against a round-level reference model, plus a directed 1-player instance.
module tb_factor_game_ctrl;

  localparam int NP = 2;
  localparam int HPW = 2;
  localparam int HPI = 3;
  localparam int NW = 4;
  localparam int NQ = 4;
  localparam int TC = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // two-player instance
  logic rst, ready_in, que_in;
  logic [NP-1:0] ans_valid, ans_ok;
  logic [3:0] state;
  logic [NW-1:0] num;
  logic num_ld;
  logic [NP*HPW-1:0] hp;
  logic [NP-1:0] active;
  logic [2:0] winner;
  logic tmo, ledr;

  // single-player instance
  logic s_rst, s_ready, s_que;
  logic [0:0] s_av, s_ok;
  logic [3:0] s_state;
  logic [NW-1:0] s_num;
  logic s_num_ld;
  logic [HPW-1:0] s_hp;
  logic [0:0] s_active;
  logic [2:0] s_winner;
  logic s_tmo, s_ledr;

  factor_game_ctrl #(.N_PLAYERS(NP), .HP_W(HPW), .HP_INIT(HPI), .NUM_W(NW),
                     .NUM_Q(NQ), .TMO_W(32), .TMO_CYC(TC)) u_dut (
    .CLK(clk), .RST(rst), .READY_IN(ready_in), .QUE_IN(que_in),
    .ANS_VALID(ans_valid), .ANS_OK(ans_ok), .STATE(state), .NUM(num),
    .NUM_LD(num_ld), .HP(hp), .ACTIVE(active), .WINNER(winner),
    .TMO(tmo), .LEDR(ledr));

  factor_game_ctrl #(.N_PLAYERS(1), .HP_W(HPW), .HP_INIT(HPI), .NUM_W(NW),
                     .NUM_Q(NQ), .TMO_W(32), .TMO_CYC(TC)) u_solo (
    .CLK(clk), .RST(s_rst), .READY_IN(s_ready), .QUE_IN(s_que),
    .ANS_VALID(s_av), .ANS_OK(s_ok), .STATE(s_state), .NUM(s_num),
    .NUM_LD(s_num_ld), .HP(s_hp), .ACTIVE(s_active), .WINNER(s_winner),
    .TMO(s_tmo), .LEDR(s_ledr));

  int n_tests = 0;
  int n_fail = 0;

  // reference model of the game at round granularity
  int m_hp[NP];
  bit m_alive[NP];
  int m_num;
  bit m_over;
  int m_win;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack_hp();
    logic [31:0] v = 0;
    for (int i = 0; i < NP; i++) v = v | (32'(m_hp[i]) << (HPW * i));
    return v;
  endfunction

  function automatic logic [31:0] pack_alive();
    logic [31:0] v = 0;
    for (int i = 0; i < NP; i++) if (m_alive[i]) v = v | (32'd1 << i);
    return v;
  endfunction

  task automatic model_new_game();
    for (int i = 0; i < NP; i++) begin
      m_hp[i] = HPI;
      m_alive[i] = 1'b1;
    end
    m_num = 0;
    m_over = 1'b0;
    m_win = 7;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_new_game();
    check("rst_state", 32'(state), 0);
    check("rst_hp", 32'(hp), pack_hp());
    check("rst_active", 32'(active), pack_alive());
    check("rst_num", 32'(num), 0);
    check("rst_num_ld", 32'(num_ld), 0);
    check("rst_winner", 32'(winner), 7);
    check("rst_tmo", 32'(tmo), 0);
    check("rst_ledr", 32'(ledr), 0);
  endtask

  task automatic start_game();
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    model_new_game();
    check("start_state", 32'(state), 1);
    check("start_num", 32'(num), 0);
    check("start_num_ld", 32'(num_ld), 1);
    check("start_hp", 32'(hp), pack_hp());
    check("start_active", 32'(active), pack_alive());
    check("start_winner", 32'(winner), 7);
  endtask

  task automatic play_round(input int mode);
    bit answered[NP];
    bit done, exp_tmo, all;
    int exp_w, c, first, cnt, idx;
    logic [NP-1:0] av, ok;
    // READY must ignore READY_IN and answers
    if ($urandom_range(0, 3) == 0) begin
      ready_in = 1'b1;
      ans_valid = NP'($urandom);
      ans_ok = NP'($urandom);
      step();
      ready_in = 1'b0;
      ans_valid = '0;
      ans_ok = '0;
      check("ready_hold", 32'(state), 1);
      check("ready_hp", 32'(hp), pack_hp());
    end
    que_in = 1'b1;
    step();
    que_in = 1'b0;
    check("ans_state", 32'(state), 2);
    check("ans_winner", 32'(winner), 7);
    for (int i = 0; i < NP; i++) answered[i] = 1'b0;
    done = 1'b0;
    exp_tmo = 1'b0;
    exp_w = 7;
    c = 0;
    while (!done) begin
      av = '0;
      ok = '0;
      case (mode)
        1: if (c == TC - 1) begin av = 2'b10; ok = 2'b10; end
        2: if (c < TC - 1 && $urandom_range(0, 3) == 0) begin av = NP'($urandom); ok = NP'($urandom); end
        3: if (c == 0) begin av = 2'b01; ok = 2'b00; end
           else if (c == 1) begin av = 2'b01; ok = 2'b01; end
           else if (c == 2) begin av = 2'b10; ok = 2'b00; end
        4: if (c == 0) begin av = 2'b11; ok = 2'b10; end
        default: ;
      endcase
      first = -1;
      for (int i = 0; i < NP; i++) begin
        if (av[i] && m_alive[i] && !answered[i]) begin
          if (ok[i]) begin
            if (first < 0) first = i;
          end else begin
            answered[i] = 1'b1;
            if (m_hp[i] > 0) m_hp[i]--;
          end
        end
      end
      all = 1'b1;
      for (int i = 0; i < NP; i++) if (m_alive[i] && !answered[i]) all = 1'b0;
      if (first >= 0) begin
        exp_w = first;
        done = 1'b1;
      end else if (all) begin
        done = 1'b1;
      end else if (c == TC - 1) begin
        exp_tmo = 1'b1;
        done = 1'b1;
        for (int i = 0; i < NP; i++)
          if (m_alive[i] && !answered[i] && m_hp[i] > 0) m_hp[i]--;
      end
      ans_valid = av;
      ans_ok = ok;
      step();
      c++;
    end
    ans_valid = '0;
    ans_ok = '0;
    check("judge_state", 32'(state), 3);
    check("judge_winner", 32'(winner), 32'(exp_w));
    check("judge_tmo", 32'(tmo), 32'(exp_tmo));
    check("judge_hp", 32'(hp), pack_hp());
    // outcome of the judge cycle
    cnt = 0;
    idx = 7;
    for (int i = 0; i < NP; i++) begin
      m_alive[i] = m_alive[i] && (m_hp[i] > 0);
      if (m_alive[i]) begin
        cnt++;
        idx = i;
      end
    end
    if (cnt <= 1) begin
      m_over = 1'b1;
      m_win = (cnt == 1) ? idx : 7;
    end else begin
      m_num = (m_num + 1) % NQ;
      m_win = exp_w;
    end
    step();
    check("post_state", 32'(state), m_over ? 4 : 1);
    check("post_winner", 32'(winner), 32'(m_win));
    check("post_active", 32'(active), pack_alive());
    check("post_num", 32'(num), 32'(m_num));
    check("post_num_ld", 32'(num_ld), 32'(!m_over));
    check("post_tmo", 32'(tmo), 0);
    check("post_ledr", 32'(ledr), 32'(m_over));
    $display("[TB] round mode=%0d cycles=%0d winner=%0d tmo=%0d hp=%0h num=%0d over=%0d",
             mode, c, exp_w, exp_tmo, pack_hp(), m_num, m_over);
  endtask

  function automatic int pick_mode();
    int r = $urandom_range(0, 9);
    if (r <= 1) return 0;
    if (r == 2) return 1;
    if (r == 7) return 3;
    if (r == 8) return 4;
    return 2;
  endfunction

  initial begin
    int rounds;
    rst = 1'b1; ready_in = 1'b0; que_in = 1'b0; ans_valid = '0; ans_ok = '0;
    s_rst = 1'b1; s_ready = 1'b0; s_que = 1'b0; s_av = '0; s_ok = '0;
    step();
    do_reset();
    step();
    check("idle_hold", 32'(state), 0);

    for (int g = 0; g < 6; g++) begin
      start_game();
      rounds = 0;
      while (!m_over && rounds < 30) begin
        play_round(pick_mode());
        rounds++;
      end
      if (m_over) begin
        que_in = 1'b1; ans_valid = '1; ans_ok = '1;
        step();
        que_in = 1'b0; ans_valid = '0; ans_ok = '0;
        check("over_hold", 32'(state), 4);
        check("over_ledr", 32'(ledr), 1);
        check("over_winner", 32'(winner), 32'(m_win));
        check("over_hp", 32'(hp), pack_hp());
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        check("over_exit", 32'(state), 0);
        check("over_exit_ledr", 32'(ledr), 0);
        check("over_exit_active", 32'(active), pack_alive());
        $display("[TB] game %0d over winner=%0d", g, m_win);
      end else begin
        do_reset();
        $display("[TB] game %0d capped, reset", g);
      end
    end

    // reset in the middle of an answer window
    start_game();
    que_in = 1'b1;
    step();
    que_in = 1'b0;
    ans_valid = 2'b01; ans_ok = 2'b00;
    step();
    ans_valid = '0;
    check("mid_hp", 32'(hp), 32'h0000000E);
    check("mid_state", 32'(state), 2);
    do_reset();
    $display("[TB] mid-round reset");

    // single player: four wins walk NUM to the last question and end the game
    step();
    s_rst = 1'b0;
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    check("solo_start_num", 32'(s_num), 0);
    for (int r = 0; r < 4; r++) begin
      s_que = 1'b1;
      step();
      s_que = 1'b0;
      s_av = 1'b1; s_ok = 1'b1;
      step();
      s_av = 1'b0; s_ok = 1'b0;
      check("solo_win_judge", 32'(s_state), 3);
      check("solo_win_winner", 32'(s_winner), 0);
      step();
      if (r < 3) begin
        check("solo_win_state", 32'(s_state), 1);
        check("solo_win_num", 32'(s_num), 32'(r + 1));
        check("solo_win_num_ld", 32'(s_num_ld), 1);
      end else begin
        check("solo_last_state", 32'(s_state), 4);
        check("solo_last_winner", 32'(s_winner), 0);
        check("solo_last_ledr", 32'(s_ledr), 1);
        check("solo_last_num", 32'(s_num), 3);
      end
      $display("[TB] solo win round %0d", r);
    end
    s_ready = 1'b1;
    step();
    check("solo_idle", 32'(s_state), 0);
    step();
    s_ready = 1'b0;
    check("solo_restart_num", 32'(s_num), 0);
    check("solo_restart_hp", 32'(s_hp), 3);
    // single player: three wrong answers exhaust HP
    for (int r = 0; r < 3; r++) begin
      s_que = 1'b1;
      step();
      s_que = 1'b0;
      s_av = 1'b1; s_ok = 1'b0;
      step();
      s_av = 1'b0;
      check("solo_lose_judge", 32'(s_state), 3);
      check("solo_lose_winner", 32'(s_winner), 7);
      check("solo_lose_hp", 32'(s_hp), 32'(2 - r));
      step();
      if (r < 2) begin
        check("solo_lose_state", 32'(s_state), 1);
        check("solo_lose_num", 32'(s_num), 32'(r + 1));
      end else begin
        check("solo_dead_state", 32'(s_state), 4);
        check("solo_dead_winner", 32'(s_winner), 7);
        check("solo_dead_active", 32'(s_active), 0);
      end
      $display("[TB] solo wrong round %0d", r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
